multicycle_ctrl: RTL and testbench

//  Control FSM for the multi-cycle LoongArch core. Sequences IF/ID/EX/MEM/WB over the shared
//  ALU, regfile and SRAMs, and issues every write enable (PC, IR, MDR, RF, data SRAM).

---
 rtl/multicycle_ctrl_pkg.sv | 21 ++
 rtl/multicycle_ctrl_if.sv | 64 ++++++
 rtl/multicycle_ctrl_lat_cnt.sv | 30 +++
 rtl/multicycle_ctrl.sv | 148 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle LoongArch control unit.
// States, PC-select encodings and the wait-counter default width.
package mc_ctrl_pkg;

  localparam int CNT_W_DEF = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_IW   = 3'd2,
    S_ID   = 3'd3,
    S_EX   = 3'd4,
    S_MEM  = 3'd5,
    S_MW   = 3'd6,
    S_WB   = 3'd7
  } state_e;

  localparam logic PC_SEQ = 1'b0;
  localparam logic PC_BR  = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control <-> datapath bundle: IR-derived class flags in,
// write enables, SRAM strobes and debug/perf outputs back.
interface multicycle_ctrl_if;

  logic        is_br;
  logic        is_load;
  logic        is_store;
  logic        gr_we;
  logic        br_taken;

  logic        inst_sram_en;
  logic        ir_we;
  logic        data_sram_en;
  logic        data_sram_we;
  logic        mdr_we;
  logic        rf_we;
  logic        pc_we;
  logic        pc_sel;
  logic        retire;
  logic [2:0]  state;
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;

  modport master (
    input  is_br,
    input  is_load,
    input  is_store,
    input  gr_we,
    input  br_taken,
    output inst_sram_en,
    output ir_we,
    output data_sram_en,
    output data_sram_we,
    output mdr_we,
    output rf_we,
    output pc_we,
    output pc_sel,
    output retire,
    output state,
    output cycle_cnt,
    output inst_cnt
  );

  modport slave (
    output is_br,
    output is_load,
    output is_store,
    output gr_we,
    output br_taken,
    input  inst_sram_en,
    input  ir_we,
    input  data_sram_en,
    input  data_sram_we,
    input  mdr_we,
    input  rf_we,
    input  pc_we,
    input  pc_sel,
    input  retire,
    input  state,
    input  cycle_cnt,
    input  inst_cnt
  );

endinterface

// File: rtl/multicycle_ctrl_lat_cnt.sv
// Loadable down-counter that absorbs SRAM read latency.
// Shared by the fetch and data wait states.
module lat_cnt
  import mc_ctrl_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_value,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle core control FSM: IF/ID/EX/MEM/WB sequencing.
// Optional perf counters enabled by MC_PERF_CNT_EN.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int INST_LAT = 1,
  parameter int MEM_LAT  = 1,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  multicycle_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] W_IPRE =
    CNT_W'(INST_LAT - 1);
  localparam logic [CNT_W-1:0] W_MPRE =
    CNT_W'(MEM_LAT - 1);

  state_e           r_state;
  logic             w_done;
  logic             w_load;
  logic             w_dec;
  logic [CNT_W-1:0] w_value;

  logic w_inst_en;
  logic w_ir_we;
  logic w_dsen;
  logic w_dswe;
  logic w_mdr_we;
  logic w_rf_we;
  logic w_pc_we;
  logic w_pc_sel;
  logic w_retire;

  // Store takes priority if decode ever flags both.
  assign w_load = (r_state == S_IF) ||
    ((r_state == S_MEM) && !bus.is_store);
  assign w_dec = (r_state == S_IW) ||
    (r_state == S_MW);
  assign w_value = (r_state == S_IF) ?
    W_IPRE : W_MPRE;

  lat_cnt #(.W(CNT_W)) u_lat (
    .clk     (clk),
    .rst_n   (resetn),
    .i_load  (w_load),
    .i_dec   (w_dec),
    .i_value (w_value),
    .o_done  (w_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_IF;
        S_IF:   r_state <= S_IW;
        S_IW:   r_state <= w_done ? S_ID : S_IW;
        S_ID:   r_state <= bus.is_br ? S_IF : S_EX;
        S_EX: begin
          if (bus.is_load || bus.is_store)
            r_state <= S_MEM;
          else
            r_state <= S_WB;
        end
        S_MEM:  r_state <= bus.is_store ? S_IF : S_MW;
        S_MW:   r_state <= w_done ? S_WB : S_MW;
        S_WB:   r_state <= S_IF;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_inst_en = 1'b0;
    w_ir_we   = 1'b0;
    w_dsen    = 1'b0;
    w_dswe    = 1'b0;
    w_mdr_we  = 1'b0;
    w_rf_we   = 1'b0;
    w_pc_we   = 1'b0;
    w_pc_sel  = PC_SEQ;
    w_retire  = 1'b0;
    case (r_state)
      S_IF: w_inst_en = 1'b1;
      S_IW: w_ir_we = w_done;
      S_ID: begin
        if (bus.is_br) begin
          w_pc_we  = 1'b1;
          w_pc_sel = bus.br_taken ? PC_BR : PC_SEQ;
          w_retire = 1'b1;
        end
      end
      S_MEM: begin
        w_dsen = 1'b1;
        w_dswe = bus.is_store;
        if (bus.is_store) begin
          w_pc_we  = 1'b1;
          w_retire = 1'b1;
        end
      end
      S_MW: w_mdr_we = w_done;
      S_WB: begin
        w_rf_we  = bus.gr_we;
        w_pc_we  = 1'b1;
        w_pc_sel = bus.br_taken ? PC_BR : PC_SEQ;
        w_retire = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.inst_sram_en = w_inst_en;
  assign bus.ir_we        = w_ir_we;
  assign bus.data_sram_en = w_dsen;
  assign bus.data_sram_we = w_dswe;
  assign bus.mdr_we       = w_mdr_we;
  assign bus.rf_we        = w_rf_we;
  assign bus.pc_we        = w_pc_we;
  assign bus.pc_sel       = w_pc_sel;
  assign bus.retire       = w_retire;
  assign bus.state        = r_state;

`ifdef MC_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_inst_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_retire)
        r_inst_cnt <= r_inst_cnt + 32'd1;
    end
  end

  assign bus.cycle_cnt = r_cycle_cnt;
  assign bus.inst_cnt  = r_inst_cnt;
`else
  assign bus.cycle_cnt = '0;
  assign bus.inst_cnt  = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (INST_LAT=1, MEM_LAT=3).
// Output vector order: inst,ir,dsen,dswe,mdr,rf,pcwe,pcsel,ret.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_pass = 0;
  int   n_chk = 0;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(
    .INST_LAT (1),
    .MEM_LAT  (3),
    .CNT_W    (3)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [8:0] w_outs;
  assign w_outs = {bus.inst_sram_en, bus.ir_we,
    bus.data_sram_en, bus.data_sram_we,
    bus.mdr_we, bus.rf_we, bus.pc_we,
    bus.pc_sel, bus.retire};

  task automatic chk(input string tag,
                     input logic [8:0] e,
                     input logic [2:0] es);
    n_chk++;
    assert (w_outs === e && bus.state === es)
      n_pass++;
    else $error("FAIL %s: got %b/%0d want %b/%0d",
      tag, w_outs, bus.state, e, es);
  endtask

  task automatic chk32(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] e);
    n_chk++;
    assert (got === e)
      n_pass++;
    else $error("FAIL %s: got %0d want %0d",
      tag, got, e);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic cls(input logic br, input logic ld,
                     input logic st, input logic we,
                     input logic tk);
    bus.is_br    = br;
    bus.is_load  = ld;
    bus.is_store = st;
    bus.gr_we    = we;
    bus.br_taken = tk;
  endtask

  task automatic front(input string tag);
    chk({tag, "_if"}, 9'h100, 3'd1); nxt();
    chk({tag, "_iw"}, 9'h080, 3'd2); nxt();
  endtask

  task automatic alu(input string tag,
                     input logic [8:0] wb);
    front(tag);
    chk({tag, "_id"}, 9'h000, 3'd3); nxt();
    chk({tag, "_ex"}, 9'h000, 3'd4); nxt();
    chk({tag, "_wb"}, wb, 3'd7); nxt();
  endtask

  task automatic br(input string tag,
                    input logic [8:0] idv);
    front(tag);
    chk({tag, "_id"}, idv, 3'd3); nxt();
  endtask

  task automatic to_mem(input string tag);
    front(tag);
    chk({tag, "_id"}, 9'h000, 3'd3); nxt();
    chk({tag, "_ex"}, 9'h000, 3'd4); nxt();
  endtask

  logic [31:0] e_cyc;
  logic [31:0] e_ins;

  initial begin
    cls(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst", 9'h000, 3'd0);
    chk32("rst_cyc", bus.cycle_cnt, 32'd0);
    chk32("rst_ins", bus.inst_cnt, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    chk("idle", 9'h000, 3'd0); nxt();

    cls(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    alu("add", 9'h00D);
    cls(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    br("beq_t", 9'h007);
    cls(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    br("beq_n", 9'h005);
    cls(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    alu("bl", 9'h00F);
    cls(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    alu("nop", 9'h005);

    cls(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    to_mem("st");
    chk("st_mem", 9'h065, 3'd5); nxt();

    cls(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    to_mem("ld");
    chk("ld_mem", 9'h040, 3'd5); nxt();
    chk("ld_mw2", 9'h000, 3'd6); nxt();
    chk("ld_mw1", 9'h000, 3'd6); nxt();
    chk("ld_mw0", 9'h010, 3'd6); nxt();
    chk("ld_wb", 9'h00D, 3'd7); nxt();

    // Second load, killed by reset in its first wait cycle.
    to_mem("ldr");
    chk("ldr_mem", 9'h040, 3'd5); nxt();
    chk("ldr_mw", 9'h000, 3'd6);
    #2 resetn = 1'b0;
    #1 chk("rst_mw", 9'h000, 3'd0);
    chk32("rst_mw_cyc", bus.cycle_cnt, 32'd0);
    @(negedge clk);
    chk("rst_hold", 9'h000, 3'd0);
    resetn = 1'b1;
    chk("idle2", 9'h000, 3'd0); nxt();

    cls(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      alu($sformatf("p%0d", i), 9'h00D);

`ifdef MC_PERF_CNT_EN
    e_cyc = 32'd51;
    e_ins = 32'd10;
`else
    e_cyc = 32'd0;
    e_ins = 32'd0;
`endif
    chk32("perf_cyc", bus.cycle_cnt, e_cyc);
    chk32("perf_ins", bus.inst_cnt, e_ins);
    chk("after", 9'h100, 3'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
